// File: rtl/seq_pkg.sv
// Shared definitions for the control-unit timing sequencer.
// Holds the default sizing constants and the per-edge priority decision enum.
package seq_pkg;

    localparam int SEQ_T_W_DEF   = 4;
    localparam int SEQ_T_MAX_DEF = 15;
    localparam int SEQ_STALL_W   = 16;

    // Outcome of the per-edge priority resolution, highest priority first.
    typedef enum logic [2:0] {
        SEQ_CLR,
        SEQ_RESTART,
        SEQ_HOLD,
        SEQ_WRAP,
        SEQ_INC,
        SEQ_IDLE
    } seq_dec_e;

endpackage

// File: rtl/seq_onehot_dec.sv
// Purely combinational binary-to-one-hot decoder.
// Output bit k is high when code equals k. Also used for the D0..D7 opcode decode.
module seq_onehot_dec #(
    parameter int T_W = 4,
    parameter int N   = 16
) (
    input  logic [T_W-1:0] code,
    output logic [N-1:0]   onehot
);

    // One comparator per output line.
    for (genvar k = 0; k < N; k++) begin : g_bit
        assign onehot[k] = (code == T_W'(k));
    end

endmodule

// File: rtl/timing_sequencer.sv
// Timing state generator for the control unit (successor of the 2-bit SC).
// Produces T, its one-hot decode, a last-state flag and wrap/restart pulses.
// Optional macro SEQ_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module timing_sequencer
    import seq_pkg::*;
#(
    parameter int T_W                = SEQ_T_W_DEF,
    parameter int T_MAX              = SEQ_T_MAX_DEF,
    parameter int RESTART_ON_RELEASE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    output logic [T_W-1:0]   T,
    output logic [T_MAX:0]   t_onehot,
    output logic             last_t,
    output logic             wrap,
    output logic             restart
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [SEQ_STALL_W-1:0] stall_cnt
`endif
);

    // Reject impossible cycle lengths at elaboration time.
    if (T_MAX < 1 || T_MAX > (2**T_W) - 1) begin : g_bad_t_max
        $error("timing_sequencer: T_MAX out of range for T_W");
    end

    localparam logic [T_W-1:0] T_LAST = T_W'(T_MAX);
    localparam bit             ROR    = (RESTART_ON_RELEASE != 0);

    logic     hold_prev;
    seq_dec_e dec;

    // Resolve this edge's action in priority order.
    always_comb begin
        dec = SEQ_IDLE;
        if (clr) begin
            dec = SEQ_CLR;
        end else if (ROR && hold_prev && !hold) begin
            dec = SEQ_RESTART;
        end else if (hold) begin
            dec = SEQ_HOLD;
        end else if (inc && (T == T_LAST)) begin
            dec = SEQ_WRAP;
        end else if (inc) begin
            dec = SEQ_INC;
        end
    end

    // State count, hold edge tracker and the two one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            T         <= '0;
            hold_prev <= 1'b0;
            wrap      <= 1'b0;
            restart   <= 1'b0;
        end else begin
            hold_prev <= hold;
            wrap      <= (dec == SEQ_WRAP);
            restart   <= (dec == SEQ_RESTART);
            case (dec)
                SEQ_CLR, SEQ_RESTART, SEQ_WRAP: T <= '0;
                SEQ_INC:                        T <= T + T_W'(1);
                default:                        T <= T;
            endcase
        end
    end

    assign last_t = (T == T_LAST);

    seq_onehot_dec #(
        .T_W (T_W),
        .N   (T_MAX + 1)
    ) u_dec (
        .code   (T),
        .onehot (t_onehot)
    );

`ifdef SEQ_STALL_CNT_EN
    // Count frozen cycles, saturating; instruction end clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
        end else if (hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + SEQ_STALL_W'(1);
        end
    end
`endif

endmodule
